// File: rtl/display_pkg.sv
// Shared 7-segment definitions: segment type, blank pattern and hex decoder.
// Segment bit order is {a,b,c,d,e,f,g} = bit6..bit0, active-high.
package display_pkg;

   typedef logic [6:0] seg_t;

   // Active-high "nothing lit" pattern; pins carry the inverse.
   localparam seg_t SEG_BLANK = 7'h00;

   function automatic seg_t hex_to_seg(input logic [3:0] hex);
      seg_t seg;
      case (hex)
         4'h0: seg = 7'h7E;
         4'h1: seg = 7'h30;
         4'h2: seg = 7'h6D;
         4'h3: seg = 7'h79;
         4'h4: seg = 7'h33;
         4'h5: seg = 7'h5B;
         4'h6: seg = 7'h5F;
         4'h7: seg = 7'h70;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h73;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h1F;
         4'hC: seg = 7'h0D;
         4'hD: seg = 7'h3D;
         4'hE: seg = 7'h4F;
         default: seg = 7'h47;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-7-segment decoder (active-high segments).
module seg7_decoder
   import display_pkg::*;
(
   input  logic [3:0] hex_i,
   output seg_t       seg_o
);

   // Pure lookup, no state.
   always_comb begin
      seg_o = hex_to_seg(hex_i);
   end

endmodule

// File: rtl/scan_display_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment driver with PWM brightness.
// Digits are scanned from NUM_DIGITS-1 (left-most) down to 0. New data is
// staged by 'load' and promoted to the active set only at a frame boundary.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
//
// Handshake: 'load' is a one-cycle strobe with no back-pressure; the inputs
// are sampled on the clock edge where load=1, and 'pending' stays high from
// the cycle after a mid-frame load until the next frame boundary promotes it.
module scan_display_ctrl
   import display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SLOT_W     = 17,
   parameter int BRIGHT_W   = 3
) (
   input  logic                    clk,
   input  logic                    clear_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dps,
   input  logic [NUM_DIGITS-1:0]   enables,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [NUM_DIGITS-1:0]   AN,
   output logic [6:0]              C,
   output logic                    DP,
   output logic                    frame_start,
   output logic                    pending
);

   localparam int             SW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [SW-1:0]  SLOT_LAST = SW'(NUM_DIGITS - 1);

   logic [SLOT_W-1:0]       tick_q, tick_d;
   logic [SW-1:0]           slot_q, slot_d;
   logic                    tick_wrap, boundary;

   logic [4*NUM_DIGITS-1:0] stg_dig_q, stg_dig_d, act_dig_q, act_dig_d;
   logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0]   stg_en_q, stg_en_d, act_en_q, act_en_d;
   logic                    pending_q, pending_d;

   logic [NUM_DIGITS-1:0]   blank;
   logic [SW+1:0]           dig_base;
   logic [3:0]              cur_dig;
   seg_t                    cur_seg;
   logic                    duty_on, lit;

   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              c_q, c_d;
   logic                    dp_q, dp_d;

   // Scan counters: tick runs every cycle, slot steps down on tick wrap.
   always_comb begin
      tick_wrap = (tick_q == {SLOT_W{1'b1}});
      boundary  = tick_wrap && (slot_q == '0);
      tick_d    = tick_q + 1'b1;
      slot_d    = slot_q;
      if (tick_wrap) begin
         slot_d = (slot_q == '0) ? SLOT_LAST : slot_q - 1'b1;
      end
   end

   // Staging/active update: a load on the boundary goes straight to active.
   always_comb begin
      stg_dig_d = stg_dig_q;
      stg_dp_d  = stg_dp_q;
      stg_en_d  = stg_en_q;
      act_dig_d = act_dig_q;
      act_dp_d  = act_dp_q;
      act_en_d  = act_en_q;
      pending_d = pending_q;
      if (load && boundary) begin
         act_dig_d = digits;
         act_dp_d  = dps;
         act_en_d  = enables;
         pending_d = 1'b0;
      end else if (load) begin
         stg_dig_d = digits;
         stg_dp_d  = dps;
         stg_en_d  = enables;
         pending_d = 1'b1;
      end else if (boundary && pending_q) begin
         act_dig_d = stg_dig_q;
         act_dp_d  = stg_dp_q;
         act_en_d  = stg_en_q;
         pending_d = 1'b0;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Leading-zero mask from the active set; active only moves at frame
   // boundaries, so the mask is stable for the whole frame.
   always_comb begin
      logic higher;
      blank  = '0;
      higher = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (higher && (act_dig_q[4*i +: 4] == 4'h0) && !act_dp_q[i]) begin
            blank[i] = 1'b1;
         end else begin
            higher = 1'b0;
         end
      end
   end
`else
   // No leading-zero suppression: every enabled digit is shown.
   always_comb begin
      blank = '0;
   end
`endif

   seg7_decoder u_dec (
      .hex_i (cur_dig),
      .seg_o (cur_seg)
   );

   // Pin values for the current (slot, tick); brightness is compared live.
   always_comb begin
      dig_base = {slot_q, 2'b00};
      cur_dig  = act_dig_q[dig_base +: 4];
      duty_on  = (tick_q[SLOT_W-1 -: BRIGHT_W] < brightness);
      lit      = act_en_q[slot_q] && !blank[slot_q] && duty_on;
      an_d     = '1;
      c_d      = ~SEG_BLANK;
      dp_d     = 1'b1;
      if (lit) begin
         an_d[slot_q] = 1'b0;
         c_d          = ~cur_seg;
         dp_d         = ~act_dp_q[slot_q];
      end
   end

   // State and registered pins; reset darkens the display immediately.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         tick_q    <= '0;
         slot_q    <= SLOT_LAST;
         stg_dig_q <= '0;
         stg_dp_q  <= '0;
         stg_en_q  <= '0;
         act_dig_q <= '0;
         act_dp_q  <= '0;
         act_en_q  <= '0;
         pending_q <= 1'b0;
         an_q      <= '1;
         c_q       <= 7'h7F;
         dp_q      <= 1'b1;
      end else begin
         tick_q    <= tick_d;
         slot_q    <= slot_d;
         stg_dig_q <= stg_dig_d;
         stg_dp_q  <= stg_dp_d;
         stg_en_q  <= stg_en_d;
         act_dig_q <= act_dig_d;
         act_dp_q  <= act_dp_d;
         act_en_q  <= act_en_d;
         pending_q <= pending_d;
         an_q      <= an_d;
         c_q       <= c_d;
         dp_q      <= dp_d;
      end
   end

   assign AN          = an_q;
   assign C           = c_q;
   assign DP          = dp_q;
   assign frame_start = boundary;
   assign pending     = pending_q;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed bench for scan_display_ctrl (NUM_DIGITS=4, SLOT_W=3, BRIGHT_W=2).
`timescale 1ns/1ps
module tb_scan_display_ctrl;

   logic        clk;
   logic        clear_n;
   logic        load;
   logic [15:0] digits;
   logic [3:0]  dps;
   logic [3:0]  enables;
   logic [1:0]  brightness;
   logic [3:0]  AN;
   logic [6:0]  C;
   logic        DP;
   logic        frame_start;
   logic        pending;

   int checks   = 0;
   int failures = 0;

   scan_display_ctrl #(
      .NUM_DIGITS (4),
      .SLOT_W     (3),
      .BRIGHT_W   (2)
   ) dut (
      .clk         (clk),
      .clear_n     (clear_n),
      .load        (load),
      .digits      (digits),
      .dps         (dps),
      .enables     (enables),
      .brightness  (brightness),
      .AN          (AN),
      .C           (C),
      .DP          (DP),
      .frame_start (frame_start),
      .pending     (pending)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0]     digits;
      logic [3:0]      dps;
      logic [3:0]      en;
      logic [1:0]      bright;
      logic [3:0][6:0] exp_c;    // pin value (active-low) per digit when lit
      logic [3:0][3:0] exp_lit;  // lit cycles per digit per frame
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Returns at the negedge where frame_start is seen (boundary cycle).
   task automatic wait_frame();
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (frame_start) return;
      end
      check("frame_timeout", 32'd0, 32'd1);
   endtask

   // Called at a negedge: present inputs with a one-cycle load strobe.
   task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
      digits  = d;
      dps     = p;
      enables = e;
      load    = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   // Observe one frame of pins; call right after the negedge following frame_start.
   task automatic observe_frame(input vec_t v);
      logic [3:0][3:0] lit;
      int slot;
      lit = '0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         slot = 3 - k / 8;
         if (AN != 4'hF) begin
            check("an_order", {28'd0, AN}, {28'd0, ~(4'b0001 << slot)});
            check("seg", {25'd0, C}, {25'd0, v.exp_c[slot]});
            check("dp", {31'd0, DP}, {31'd0, ~v.dps[slot]});
            lit[slot] = lit[slot] + 4'd1;
         end else begin
            check("dark_pins", {24'd0, C, DP}, {24'd0, 7'h7F, 1'b1});
         end
      end
      for (int s = 0; s < 4; s++) begin
         check($sformatf("lit_count_d%0d", s), {28'd0, lit[s]}, {28'd0, v.exp_lit[s]});
      end
   endtask

   initial begin
      int cnt;
      int lit_total;

      vecs[0] = '{16'h12AF, 4'b0000, 4'hF, 2'd3,
                  {7'h4F, 7'h12, 7'h08, 7'h38}, {4'd6, 4'd6, 4'd6, 4'd6}};
      vecs[1] = '{16'h12AF, 4'b0100, 4'hF, 2'd1,
                  {7'h4F, 7'h12, 7'h08, 7'h38}, {4'd2, 4'd2, 4'd2, 4'd2}};
      vecs[2] = '{16'h12AF, 4'b1111, 4'hF, 2'd0,
                  {7'h4F, 7'h12, 7'h08, 7'h38}, {4'd0, 4'd0, 4'd0, 4'd0}};
`ifdef LEADING_ZERO_BLANK_EN
      vecs[3] = '{16'h0050, 4'b0000, 4'b1010, 2'd2,
                  {7'h01, 7'h7F, 7'h24, 7'h7F}, {4'd0, 4'd0, 4'd4, 4'd0}};
      vecs[4] = '{16'h0000, 4'b0000, 4'hF, 2'd3,
                  {7'h01, 7'h01, 7'h01, 7'h01}, {4'd0, 4'd0, 4'd0, 4'd6}};
      vecs[5] = '{16'h0050, 4'b0000, 4'hF, 2'd3,
                  {7'h01, 7'h01, 7'h24, 7'h01}, {4'd0, 4'd0, 4'd6, 4'd6}};
`else
      vecs[3] = '{16'h0050, 4'b0000, 4'b1010, 2'd2,
                  {7'h01, 7'h7F, 7'h24, 7'h7F}, {4'd4, 4'd0, 4'd4, 4'd0}};
      vecs[4] = '{16'h0000, 4'b0000, 4'hF, 2'd3,
                  {7'h01, 7'h01, 7'h01, 7'h01}, {4'd6, 4'd6, 4'd6, 4'd6}};
      vecs[5] = '{16'h0050, 4'b0000, 4'hF, 2'd3,
                  {7'h01, 7'h01, 7'h24, 7'h01}, {4'd6, 4'd6, 4'd6, 4'd6}};
`endif

      // Reset
      clear_n    = 1'b0;
      load       = 1'b0;
      digits     = '0;
      dps        = '0;
      enables    = '0;
      brightness = 2'd3;
      #12;
      check("reset_pins", {20'd0, AN, C, DP}, {20'd0, 4'hF, 7'h7F, 1'b1});
      check("reset_pending", {31'd0, pending}, 32'd0);
      check("reset_frame_start", {31'd0, frame_start}, 32'd0);
      @(negedge clk);
      clear_n = 1'b1;

      // No load: display stays dark for 100 cycles
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("idle_dark", {20'd0, AN, C, DP}, {20'd0, 4'hF, 7'h7F, 1'b1});
      end

      // frame_start period
      wait_frame();
      cnt = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         cnt++;
         if (frame_start) break;
      end
      check("frame_period", cnt, 32'd32);

      // Table-driven vectors: mid-frame load, promoted at the next boundary
      foreach (vecs[i]) begin
         wait_frame();
         repeat (3) @(negedge clk);
         brightness = vecs[i].bright;
         do_load(vecs[i].digits, vecs[i].dps, vecs[i].en);
         @(negedge clk);
         check("pending_set", {31'd0, pending}, 32'd1);
         wait_frame();
         @(negedge clk);
         check("pending_clear", {31'd0, pending}, 32'd0);
         observe_frame(vecs[i]);
      end

      // Mid-frame loads: old value held, only the last load ever appears
      brightness = 2'd3;
      wait_frame();
      do_load(16'h8888, 4'b0000, 4'hF);
      wait_frame();
      @(negedge clk);
      repeat (5) @(negedge clk);
      do_load(16'h3333, 4'b0000, 4'hF);
      @(negedge clk);
      check("pending_first_load", {31'd0, pending}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("old_held_a", {31'd0, (C == 7'h00) || (C == 7'h7F)}, 32'd1);
      end
      do_load(16'h4444, 4'b0000, 4'hF);
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (frame_start) break;
         cnt++;
         check("old_held_b", {31'd0, (C == 7'h00) || (C == 7'h7F)}, 32'd1);
      end
      check("boundary_reached", {31'd0, frame_start}, 32'd1);
      check("pending_at_boundary", {31'd0, pending}, 32'd1);
      @(negedge clk);
      check("pending_after_boundary", {31'd0, pending}, 32'd0);
      check("old_held_lag", {31'd0, (C == 7'h00) || (C == 7'h7F)}, 32'd1);
      lit_total = 0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         if (AN != 4'hF) begin
            lit_total++;
            check("last_load_wins", {25'd0, C}, {25'd0, 7'h4C});
         end
      end
      check("last_load_lit_total", lit_total, 32'd24);

      // Load on the boundary cycle: bypasses staging, shown in this frame
      wait_frame();
      do_load(16'h9999, 4'b0000, 4'hF);
      @(negedge clk);
      check("bypass_pending", {31'd0, pending}, 32'd0);
      @(negedge clk);
      check("bypass_an", {28'd0, AN}, {28'd0, 4'h7});
      check("bypass_seg", {25'd0, C}, {25'd0, 7'h0C});

      // Async reset mid-slot: dark at once, staged data lost, scan restarts at slot 3
      wait_frame();
      @(negedge clk);
      @(negedge clk);
      do_load(16'h1234, 4'b1111, 4'hF);
      check("pre_reset_lit", {28'd0, AN}, {28'd0, 4'h7});
      check("pre_reset_pending", {31'd0, pending}, 32'd1);
      #1 clear_n = 1'b0;
      #1;
      check("async_dark", {20'd0, AN, C, DP}, {20'd0, 4'hF, 7'h7F, 1'b1});
      check("async_pending", {31'd0, pending}, 32'd0);
      check("async_frame_start", {31'd0, frame_start}, 32'd0);
      @(negedge clk);
      clear_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         cnt++;
         if (frame_start) break;
         check("post_reset_dark", {28'd0, AN}, {28'd0, 4'hF});
      end
      check("restart_slot3", cnt, 32'd31);
      for (int i = 0; i < 33; i++) begin
         @(negedge clk);
         check("staged_lost", {28'd0, AN}, {28'd0, 4'hF});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
